bcd_to_bin16: RTL

BCD_TO_BIN16 -- requirements
Module: bcd_to_bin16

---
 rtl/bcd_to_bin16_pkg.sv | 27 ++
 rtl/bcd_to_bin16_mul10_add.sv | 12 +
 rtl/bcd_to_bin16.sv | 104 ++++++++++
 3 files changed

// File: rtl/bcd_to_bin16_pkg.sv
// Shared types and constants for the 5-digit signed BCD to 16-bit binary converter.
package bcd_to_bin16_pkg;

    localparam int BCD_DIGITS = 5;
    localparam int BIN_W      = 16;
    localparam int ACC_W      = 17;

    localparam logic [ACC_W-1:0] POS_MAX = 17'd32767;
    localparam logic [ACC_W-1:0] NEG_MAX = 17'd32768;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef logic [BCD_DIGITS-1:0][3:0] bcd_vec_t;

    function automatic logic has_invalid(input bcd_vec_t d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (d[i] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_bin16_mul10_add.sv
// One Horner step: acc*10 + digit using shifts, full 17-bit width.
module mul10_add
    import bcd_to_bin16_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] result
);

    assign result = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};

endmodule

// File: rtl/bcd_to_bin16.sv
// Sequential signed BCD to two's-complement converter: one digit per cycle,
// saturating to the 16-bit signed range, with an invalid-digit flag.
module bcd_to_bin16
    import bcd_to_bin16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             negative,
    input  logic [3:0]       bcd_digit0,
    input  logic [3:0]       bcd_digit1,
    input  logic [3:0]       bcd_digit2,
    input  logic [3:0]       bcd_digit3,
    input  logic [3:0]       bcd_digit4,
    output logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             invalid
);

    state_t           state, state_nxt;
    bcd_vec_t         digits_q;
    logic             neg_q;
    logic             inv_pend;
    logic [2:0]       idx;
    logic [ACC_W-1:0] acc, acc_nxt;
    bcd_vec_t         digits_in;

    assign digits_in = {bcd_digit4, bcd_digit3, bcd_digit2, bcd_digit1, bcd_digit0};
    assign busy      = (state != IDLE);

    mul10_add u_mul10_add (
        .acc    (acc),
        .digit  (digits_q[idx]),
        .result (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (idx == 3'd0) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            neg_q    <= 1'b0;
            inv_pend <= 1'b0;
            idx      <= 3'd0;
            acc      <= '0;
            bin      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    digits_q <= digits_in;
                    neg_q    <= negative;
                    inv_pend <= has_invalid(digits_in);
                    idx      <= 3'(BCD_DIGITS - 1);
                    acc      <= '0;
                end
                CONV: begin
                    acc <= acc_nxt;
                    idx <= idx - 3'd1;
                end
                FIN: begin
                    done     <= 1'b1;
                    invalid  <= 1'b0;
                    overflow <= 1'b0;
                    if (inv_pend) begin
                        bin     <= '0;
                        invalid <= 1'b1;
                    end else if (!neg_q && acc > POS_MAX) begin
                        bin      <= 16'h7FFF;
                        overflow <= 1'b1;
                    end else if (neg_q && acc > NEG_MAX) begin
                        bin      <= 16'h8000;
                        overflow <= 1'b1;
                    end else if (neg_q) begin
                        // -32768 and -0 both fall out of plain 16-bit negation
                        bin <= -acc[BIN_W-1:0];
                    end else begin
                        bin <= acc[BIN_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
